// File: rtl/control_seq_if.sv
// Signal bundle between the instruction source/datapath (master) and control_seq (slave).
// CONTROL_SEQ_PERF_EN adds the InstrCount/StallCount counter outputs.
interface control_seq_if #(
    parameter int unsigned OPW    = 4,
    parameter int unsigned ALUOPW = 3
);
    logic              InstrValid;
    logic [OPW-1:0]    Instr_i;
    logic              InstrReady;
    logic              MemReady;
    logic              Zero_i;
    logic              Branch;
    logic              MemRead;
    logic              MemWrite;
    logic              ALUSrc;
    logic              MoveAcc;
    logic [ALUOPW-1:0] ALUOp;
    logic              PCEn;
    logic              PCLoad;
    logic              MemErr;
`ifdef CONTROL_SEQ_PERF_EN
    logic [15:0]       InstrCount;
    logic [15:0]       StallCount;
`endif

    modport master (
        output InstrValid, Instr_i, MemReady, Zero_i,
`ifdef CONTROL_SEQ_PERF_EN
        input  InstrCount, StallCount,
`endif
        input  InstrReady, Branch, MemRead, MemWrite, ALUSrc, MoveAcc,
               ALUOp, PCEn, PCLoad, MemErr
    );

    modport slave (
        input  InstrValid, Instr_i, MemReady, Zero_i,
`ifdef CONTROL_SEQ_PERF_EN
        output InstrCount, StallCount,
`endif
        output InstrReady, Branch, MemRead, MemWrite, ALUSrc, MoveAcc,
               ALUOp, PCEn, PCLoad, MemErr
    );
endinterface

// File: rtl/control_seq.sv
// control_seq: one-hot IDLE/EXEC/MEM/COMMIT sequencer decoding a latched opcode into datapath controls.
// Define CONTROL_SEQ_PERF_EN to add the InstrCount/StallCount performance counters.
package control_seq_pkg;
    localparam logic [3:0] kRXOR    = 4'd0;
    localparam logic [3:0] kXOR     = 4'd1;
    localparam logic [3:0] kSLT     = 4'd2;
    localparam logic [3:0] kFLIP    = 4'd3;
    localparam logic [3:0] kADD     = 4'd4;
    localparam logic [3:0] kSUB     = 4'd5;
    localparam logic [3:0] kSLL     = 4'd6;
    localparam logic [3:0] kSR      = 4'd7;
    localparam logic [3:0] kMOVEI   = 4'd8;
    localparam logic [3:0] kMOVEACC = 4'd9;
    localparam logic [3:0] kLB      = 4'd10;
    localparam logic [3:0] kSB      = 4'd11;
    localparam logic [3:0] kBEQ     = 4'd12;
    localparam logic [3:0] kBNE     = 4'd13;
endpackage

module control_seq
    import control_seq_pkg::*;
#(
    parameter int unsigned OPW         = 4,
    parameter int unsigned ALUOPW      = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic          Clk,
    input  logic          Reset_n,
    control_seq_if.slave  bus
);

    localparam logic [OPW-1:0] OP_RXOR    = OPW'(kRXOR);
    localparam logic [OPW-1:0] OP_XOR     = OPW'(kXOR);
    localparam logic [OPW-1:0] OP_SLT     = OPW'(kSLT);
    localparam logic [OPW-1:0] OP_FLIP    = OPW'(kFLIP);
    localparam logic [OPW-1:0] OP_ADD     = OPW'(kADD);
    localparam logic [OPW-1:0] OP_SUB     = OPW'(kSUB);
    localparam logic [OPW-1:0] OP_SLL     = OPW'(kSLL);
    localparam logic [OPW-1:0] OP_SR      = OPW'(kSR);
    localparam logic [OPW-1:0] OP_MOVEI   = OPW'(kMOVEI);
    localparam logic [OPW-1:0] OP_MOVEACC = OPW'(kMOVEACC);
    localparam logic [OPW-1:0] OP_LB      = OPW'(kLB);
    localparam logic [OPW-1:0] OP_SB      = OPW'(kSB);
    localparam logic [OPW-1:0] OP_BEQ     = OPW'(kBEQ);
    localparam logic [OPW-1:0] OP_BNE     = OPW'(kBNE);

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        EXEC   = 4'b0010,
        MEM    = 4'b0100,
        COMMIT = 4'b1000
    } state_e;

    state_e         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic           taken_q, taken_d;
    logic [7:0]     wait_q, wait_d;

    logic dec_alu, dec_imm, dec_macc, dec_lb, dec_sb, dec_beq, dec_bne;
    logic ctrl_en, alu_en, pc_en, pc_load, mem_err;

    // Opcode decode from the latched opcode only; undefined codes decode to nothing.
    always_comb begin
        dec_alu  = op_q inside {OP_RXOR, OP_XOR, OP_SLT, OP_FLIP,
                                OP_ADD, OP_SUB, OP_SLL, OP_SR};
        dec_imm  = op_q inside {OP_SLL, OP_SR, OP_MOVEI};
        dec_macc = (op_q == OP_MOVEACC);
        dec_lb   = (op_q == OP_LB);
        dec_sb   = (op_q == OP_SB);
        dec_beq  = (op_q == OP_BEQ);
        dec_bne  = (op_q == OP_BNE);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        taken_d = taken_q;
        wait_d  = wait_q;
        ctrl_en = 1'b0;
        alu_en  = 1'b0;
        pc_en   = 1'b0;
        pc_load = 1'b0;
        mem_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.InstrValid) begin
                    op_d    = bus.Instr_i;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                ctrl_en = 1'b1;
                alu_en  = 1'b1;
                taken_d = (dec_beq & bus.Zero_i) | (dec_bne & ~bus.Zero_i);
                if (dec_lb | dec_sb) begin
                    wait_d  = '0;
                    state_d = MEM;
                end else begin
                    state_d = COMMIT;
                end
            end
            MEM: begin
                ctrl_en = 1'b1;
                if (bus.MemReady) begin
                    state_d = COMMIT;
                end else begin
                    wait_d = wait_q + 8'd1;
                    // Timeout abandons the instruction without touching the PC.
                    if (wait_q == WAIT_LIMIT) begin
                        mem_err = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            COMMIT: begin
                pc_load = taken_q;
                pc_en   = ~taken_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            taken_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            taken_q <= taken_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        bus.InstrReady = (state_q == IDLE);
        bus.Branch     = ctrl_en & (dec_beq | dec_bne);
        bus.MemRead    = ctrl_en & dec_lb;
        bus.MemWrite   = ctrl_en & dec_sb;
        bus.ALUSrc     = ctrl_en & dec_imm;
        bus.MoveAcc    = ctrl_en & (dec_macc | dec_lb);
        bus.ALUOp      = (alu_en & dec_alu) ? op_q[ALUOPW-1:0] : '0;
        bus.PCEn       = pc_en;
        bus.PCLoad     = pc_load;
        bus.MemErr     = mem_err;
    end

`ifdef CONTROL_SEQ_PERF_EN
    logic [15:0] instr_count_q, instr_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    // Both counters wrap naturally at 16 bits.
    always_comb begin
        instr_count_d = instr_count_q;
        stall_count_d = stall_count_q;
        if (state_q == COMMIT) begin
            instr_count_d = instr_count_q + 16'd1;
        end
        if ((state_q == MEM) && !bus.MemReady) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            instr_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            instr_count_q <= instr_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        bus.InstrCount = instr_count_q;
        bus.StallCount = stall_count_q;
    end
`endif

endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 Parameter OPW, default 4, opcode width; opcode constants (kRXOR..kBNE) come from package definitions, zero-extended to OPW.
REQ-002 Parameter ALUOPW, default 3, ALUOp width.
REQ-003 Parameter MEM_TIMEOUT, default 15, maximum MEM-state wait cycles before error; legal range 1..255.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 InstrValid  input  1  opcode on Instr_i is valid.
REQ-007 Instr_i  input  OPW  opcode.
REQ-008 InstrReady  output  1  sequencer accepts an opcode this cycle.
REQ-009 MemReady  input  1  data memory completed the current read/write.
REQ-010 Zero_i  input  1  ALU zero flag, for branch resolution.
REQ-011 Branch, MemRead, MemWrite, ALUSrc, MoveAcc  output  1 each  datapath controls.
REQ-012 ALUOp  output  ALUOPW  ALU operation select.
REQ-013 PCEn  output  1  one-cycle pulse: PC advances by 1.
REQ-014 PCLoad  output  1  one-cycle pulse: PC loads branch target.
REQ-015 MemErr  output  1  one-cycle pulse: memory timeout.

Function
REQ-016 States are IDLE, EXEC, MEM and COMMIT, encoded one-hot.
REQ-017 InstrReady = 1 only in IDLE; on InstrValid & InstrReady the opcode is latched into op_q and the FSM goes to EXEC; otherwise it stays in IDLE.
REQ-018 EXEC lasts one cycle.
  - kLB/kSB: next state MEM.
  - All other opcodes: next state COMMIT.
REQ-019 Controls are decoded only from op_q, only in EXEC and MEM, and are 0 in IDLE and COMMIT:
  - kMOVEACC: MoveAcc.
  - kLB: MemRead, MoveAcc.
  - kSB: MemWrite.
  - kSLL/kSR/kMOVEI: ALUSrc.
  - kBEQ/kBNE: Branch.
REQ-020 ALUOp = op_q[ALUOPW-1:0] in EXEC for kRXOR, kXOR, kSLT, kFLIP, kADD, kSUB, kSLL and kSR; otherwise 0.
REQ-021 Zero_i is sampled at the end of EXEC into taken_q.
  - taken_q = (kBEQ & Zero_i) | (kBNE & ~Zero_i).
  - taken_q = 0 for non-branch opcodes.
REQ-022 MEM holds MemRead or MemWrite until MemReady = 1, then goes to COMMIT.
  - A wait counter (8 bits) clears on entry to MEM and increments every cycle MemReady = 0.
REQ-023 If MemReady = 0 while the wait counter = MEM_TIMEOUT-1: MemErr pulses for 1 cycle, the FSM goes to IDLE, and PCEn/PCLoad are not asserted.
REQ-024 In COMMIT: PCLoad = taken_q, PCEn = ~taken_q, each for exactly 1 cycle; the FSM then goes to IDLE.
REQ-025 Latency from accept edge to PC pulse:
  - Non-memory opcode: 2 cycles.
  - Memory opcode with MemReady already high in the first MEM cycle: 3 cycles.
  - Throughput: 1 opcode per 3 cycles minimum.
REQ-026 InstrValid while not in IDLE is ignored; no queuing.
REQ-027 Undefined opcodes: all controls 0 and COMMIT with PCEn = 1, treated as NOP.

Reset
REQ-028 Reset_n low asynchronously forces IDLE, op_q = 0, taken_q = 0 and wait counter = 0; all outputs are 0 except InstrReady, which goes to 1 once in IDLE.
REQ-029 Reset asserted mid-EXEC/MEM/COMMIT aborts the instruction; no PCEn, PCLoad or MemErr pulse follows reset release.

Configuration
REQ-030 Macro CONTROL_SEQ_PERF_EN.
  - When defined: adds outputs InstrCount[15:0], incremented on each COMMIT, and StallCount[15:0], incremented each MEM cycle with MemReady = 0.
  - Both counters wrap at 0xFFFF to 0 and are cleared by reset.
  - When undefined: these ports and counters are absent, and all other behaviour is identical.

Verification
REQ-031 Reset low during MEM, then release -> IDLE, InstrReady = 1, no PCEn/PCLoad/MemErr within 5 cycles.
REQ-032 Accept kADD at cycle 0 -> EXEC at cycle 1 with ALUOp = kADD[2:0]; PCEn = 1 at cycle 2 only; InstrReady = 1 at cycle 3.
REQ-033 kBEQ with Zero_i = 1 in EXEC -> Branch = 1 in EXEC and PCLoad = 1, PCEn = 0 in COMMIT; kBNE with Zero_i = 1 -> PCEn = 1, PCLoad = 0.
REQ-034 kLB with MemReady held 0 for 3 cycles, then 1 -> MemRead = MoveAcc = 1 for 4 MEM cycles, PCEn on the following cycle; with CONTROL_SEQ_PERF_EN, StallCount = 3 and InstrCount = 1.
REQ-035 kSB with MemReady never asserted, MEM_TIMEOUT = 4 -> MemWrite high for 4 cycles, MemErr pulses in the 4th MEM cycle, then IDLE with no PCEn.
REQ-036 InstrValid held high continuously with alternating opcodes -> an accept every 3 cycles, none while busy; with CONTROL_SEQ_PERF_EN, InstrCount wraps 0xFFFF -> 0.
